// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one line-wide memory port between two cache masters
// (M0 = instruction cache, M1 = data cache). One master is granted at a
// time; the grant covers exactly the channels the master had requested
// when it was granted and is released once those have completed (or the
// master withdraws every request). Ties are broken round-robin.
//
// Ports:
//   clk, rstn                 clock, synchronous active-high reset
//   mX_ren/raddr              master read request and address
//   mX_wen/waddr/wdata/wmask  master write request, address, data, mask
//   mX_rdata                  read data (memory data broadcast)
//   mX_rvalid/wvalid          completions, only to the granted master
//   mem_*                     shared memory port
//   busy, grant_id            grant active / granted master
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        m0_ren,
    input  logic [ADDR_WIDTH-1:0]       m0_raddr,
    input  logic                        m0_wen,
    input  logic [ADDR_WIDTH-1:0]       m0_waddr,
    input  logic [DATA_WIDTH*2-1:0]     m0_wdata,
    input  logic [DATA_WIDTH*2/8-1:0]   m0_wmask,
    output logic [DATA_WIDTH*2-1:0]     m0_rdata,
    output logic                        m0_rvalid,
    output logic                        m0_wvalid,
    input  logic                        m1_ren,
    input  logic [ADDR_WIDTH-1:0]       m1_raddr,
    input  logic                        m1_wen,
    input  logic [ADDR_WIDTH-1:0]       m1_waddr,
    input  logic [DATA_WIDTH*2-1:0]     m1_wdata,
    input  logic [DATA_WIDTH*2/8-1:0]   m1_wmask,
    output logic [DATA_WIDTH*2-1:0]     m1_rdata,
    output logic                        m1_rvalid,
    output logic                        m1_wvalid,
    output logic                        mem_ren,
    output logic                        mem_wen,
    output logic [ADDR_WIDTH-1:0]       mem_raddr,
    output logic [ADDR_WIDTH-1:0]       mem_waddr,
    output logic [DATA_WIDTH*2-1:0]     mem_wdata,
    output logic [DATA_WIDTH*2/8-1:0]   mem_wmask,
    input  logic [DATA_WIDTH*2-1:0]     mem_rdata,
    input  logic                        mem_rvalid,
    input  logic                        mem_wvalid,
    output logic                        busy,
    output logic                        grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_s;
    logic       rr_last_r;
    logic       rr_last_s;
    logic       r_pend_r;
    logic       r_pend_s;
    logic       w_pend_r;
    logic       w_pend_s;
    logic       req0_s;
    logic       req1_s;
    logic       g_ren_s;
    logic       g_wen_s;

    // Read data is broadcast; masters qualify it with their own rvalid.
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    assign req0_s = m0_ren | m0_wen;
    assign req1_s = m1_ren | m1_wen;

    // Live request lines of whichever master currently holds the grant.
    always_comb begin
        g_ren_s = 1'b0;
        g_wen_s = 1'b0;
        case (state_r)
            GNT0: begin
                g_ren_s = m0_ren;
                g_wen_s = m0_wen;
            end
            GNT1: begin
                g_ren_s = m1_ren;
                g_wen_s = m1_wen;
            end
            default: begin
                g_ren_s = 1'b0;
                g_wen_s = 1'b0;
            end
        endcase
    end

    // Arbitration and completion tracking: next state, pend flags, round-robin pointer.
    always_comb begin
        state_s   = state_r;
        rr_last_s = rr_last_r;
        r_pend_s  = r_pend_r;
        w_pend_s  = w_pend_r;
        case (state_r)
            IDLE: begin
                // rr_last=1 means M1 was served last, so M0 wins a tie.
                if (req0_s && (!req1_s || rr_last_r)) begin
                    state_s   = GNT0;
                    r_pend_s  = m0_ren;
                    w_pend_s  = m0_wen;
                    rr_last_s = 1'b0;
                end else if (req1_s) begin
                    state_s   = GNT1;
                    r_pend_s  = m1_ren;
                    w_pend_s  = m1_wen;
                    rr_last_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            GNT0, GNT1: begin
                if (!(g_ren_s || g_wen_s)) begin
                    // Master withdrew everything: abandon the grant.
                    state_s  = IDLE;
                    r_pend_s = 1'b0;
                    w_pend_s = 1'b0;
                end else begin
                    r_pend_s = r_pend_r & ~mem_rvalid;
                    w_pend_s = w_pend_r & ~mem_wvalid;
                    if (!r_pend_s && !w_pend_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                r_pend_s = 1'b0;
                w_pend_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-grant drops it silently.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_r   <= IDLE;
            rr_last_r <= 1'b1;
            r_pend_r  <= 1'b0;
            w_pend_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            rr_last_r <= rr_last_s;
            r_pend_r  <= r_pend_s;
            w_pend_r  <= w_pend_s;
        end
    end

    // Port steering: memory requests gated by pend flags (late requests are
    // not served), address/data passed whenever granted, completions routed.
    always_comb begin
        busy      = 1'b0;
        grant_id  = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        m0_rvalid = 1'b0;
        m0_wvalid = 1'b0;
        m1_rvalid = 1'b0;
        m1_wvalid = 1'b0;
        case (state_r)
            GNT0: begin
                busy      = 1'b1;
                grant_id  = 1'b0;
                mem_ren   = m0_ren & r_pend_r;
                mem_wen   = m0_wen & w_pend_r;
                mem_raddr = m0_raddr;
                mem_waddr = m0_waddr;
                mem_wdata = m0_wdata;
                mem_wmask = m0_wmask;
                m0_rvalid = mem_rvalid & r_pend_r;
                m0_wvalid = mem_wvalid & w_pend_r;
            end
            GNT1: begin
                busy      = 1'b1;
                grant_id  = 1'b1;
                mem_ren   = m1_ren & r_pend_r;
                mem_wen   = m1_wen & w_pend_r;
                mem_raddr = m1_raddr;
                mem_waddr = m1_waddr;
                mem_wdata = m1_wdata;
                mem_wmask = m1_wmask;
                m1_rvalid = mem_rvalid & r_pend_r;
                m1_wvalid = mem_wvalid & w_pend_r;
            end
            default: begin
                busy      = 1'b0;
            end
        endcase
    end

endmodule
